// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit path: byte width, default queue
// depth and the 2-bit launch FSM encoding.
package uart_tx_queue_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO: storage, wrapping read/write pointers, occupancy count
// and registered full/empty flags. Flush clears pointers and count only.
module byte_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_c_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // Self-protecting: a push into a full queue or a pop from an empty one is a no-op.
  assign push_ok = push_i && !full_q && !flush_i;
  assign pop_ok  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage is deliberately unreset; nothing reads it while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign head_c_o = mem_q[rptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Host-side byte queue in front of a UART transmitter: buffers writes, flags
// dropped bytes, and launches one byte per UART idle period with an OE pulse.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BYTE_W-1:0] WDATA,
  input  logic              WE,
  input  logic              FLUSH,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AW:0]       COUNT,
  output logic              OVF,
  output logic [BYTE_W-1:0] DIN,
  output logic              OE,
  input  logic              RDY
);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] din_q, din_d;
  logic              oe_q, oe_d;
  logic              ovf_q, ovf_d;
  logic              pop_c;
  logic              push_c;
  logic [BYTE_W-1:0] head_c;
  logic              fifo_full;
  logic              fifo_empty;

  // FULL is the registered flag, so a write in a popping cycle is still rejected.
  assign push_c = WE && !fifo_full;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .flush_i  (FLUSH),
    .push_i   (push_c),
    .wdata_i  (WDATA),
    .pop_i    (pop_c),
    .head_c_o (head_c),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (COUNT)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Launch sequencing; FLUSH only blocks a new launch, never an in-flight one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!FLUSH && !fifo_empty && RDY) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (RDY) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop_c = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
    din_d = din_q;
    oe_d  = (state_d == ST_ISSUE);
    ovf_d = ovf_q;
    if (pop_c) begin
      din_d = head_c;
    end
    if (FLUSH) begin
      ovf_d = 1'b0;
    end else if (WE && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      din_q <= '0;
      oe_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      din_q <= din_d;
      oe_q  <= oe_d;
      ovf_q <= ovf_d;
    end
  end

  assign FULL  = fifo_full;
  assign EMPTY = fifo_empty;
  assign OVF   = ovf_q;
  assign DIN   = din_q;
  assign OE    = oe_q;

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, range 2..256.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning pointer width.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port WDATA  input  8  byte from the host.
REQ-006 SHALL have port WE  input  1  host write strobe; one byte per high cycle.
REQ-007 SHALL have port FLUSH  input  1  synchronous clear of the queue and OVF.
REQ-008 SHALL have port FULL  output  1  COUNT == DEPTH.
REQ-009 SHALL have port EMPTY  output  1  COUNT == 0.
REQ-010 SHALL have port COUNT  output  AW+1  bytes held, excluding the byte being sent.
REQ-011 SHALL have port OVF  output  1  sticky flag: a write was dropped.
REQ-012 SHALL have port DIN  output  8  byte to the UART transmitter.
REQ-013 SHALL have port OE  output  1  one-cycle start pulse to the UART.
REQ-014 SHALL have port RDY  input  1  UART transmitter idle.

Function
REQ-015 SHALL implement a circular FIFO with read/write pointers of AW bits that wrap DEPTH-1 -> 0.
REQ-016 SHALL accept WE && !FULL: store WDATA at the write pointer and increment COUNT on the next edge.
REQ-017 SHALL drop WE && FULL: leave FIFO contents unchanged and set OVF.
REQ-018 SHALL evaluate FULL from the registered state in the same cycle, so WE is rejected even when a pop occurs in that cycle.
REQ-019 SHALL run a launch FSM with states IDLE, ISSUE, SETTLE and WAIT.
REQ-020 SHALL go IDLE -> ISSUE when !EMPTY && RDY, popping the head into the DIN register and decrementing COUNT.
REQ-021 SHALL assert OE for exactly one cycle in ISSUE, then go to SETTLE.
REQ-022 SHALL go SETTLE -> WAIT unconditionally after one cycle, giving the UART time to drop RDY.
REQ-023 SHALL go WAIT -> IDLE when RDY == 1.
REQ-024 SHALL hold DIN stable from ISSUE until the next pop.
REQ-025 SHALL NOT emit back-to-back OE pulses; OE pulses are at least 3 cycles apart.
REQ-026 SHALL make the minimum latency from a write into an empty queue with RDY=1 to OE high equal to 2 cycles (write edge, pop edge).
REQ-027 SHALL count a simultaneous write and pop as one in and one out, leaving COUNT unchanged.
REQ-028 SHALL make FLUSH take priority over WE and pop: pointers, COUNT and OVF go to 0.
REQ-029 SHALL let a FLUSH arriving in ISSUE, SETTLE or WAIT finish the current handshake; the in-flight byte is not recalled.

Reset
REQ-030 SHALL, while RST is low, force pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, OVF = 0, DIN = 8'h00, OE = 0 and state = IDLE, independent of CLK.
REQ-031 SHALL, on reset mid-transfer, abandon the transfer; the UART is reset by the same RST.
REQ-032 SHALL leave FIFO storage contents unreset; they are not observable while EMPTY.

Structure
REQ-033 SHALL place the FSM state encodings (2-bit) and the default DEPTH in a shared package/header used by the UART blocks.
REQ-034 SHALL isolate storage and pointer logic in one sub-module, byte_fifo, with push/pop/full/empty/count; uart_tx_queue adds the FSM, OVF and DIN register.

Verification
REQ-035 SHALL verify, at 50 MHz with a real UART at 115200 baud: write "U" once -> OE at cycle +2, DIN = 8'h55, TXD frame 8680 ns per bit, EMPTY = 1 afterwards.
REQ-036 SHALL verify a 16-byte burst 8'h00..8'h0F while RDY = 0 -> FULL = 1 and COUNT = 16; a 17th write sets OVF and is dropped; on release, bytes appear on DIN in order with no 8'h10.
REQ-037 SHALL verify write on the same cycle as a pop with COUNT = 16 -> write rejected, OVF = 1, COUNT = 15 next cycle.
REQ-038 SHALL verify FLUSH asserted in WAIT with 5 bytes queued -> COUNT = 0 and OVF = 0; the current frame completes; no further OE.
REQ-039 SHALL verify RST low for 20 ns mid-frame -> all outputs at reset values immediately; the next written byte transmits correctly.
REQ-040 SHALL verify that an RDY glitch (low, then high one cycle after OE) -> FSM returns to IDLE and the next byte waits for RDY = 1, never issuing OE while RDY = 0.
